census_disparity_wta: RTL and testbench
=======================================

// Module: census_disparity_wta
// PURPOSE
//  Consumes left/right Census codes in lockstep raster order from the census stage.
//  Per pixel: Hamming cost against right codes at disparities 0..dmax; winner-take-all minimum.
//  Emits a disparity map stream toward depth conversion; one candidate per cycle.
//  Ready/valid on both sides.
// PARAMETERS
//  WIDTH       320  pixels per row (columns of census codes)
//  HEIGHT      240  rows per frame
//  CODE_WIDTH  8    Census code bits (WINDOW_SIZE^2-1)
//  MAX_DISP    16   number of disparity candidates, d = 0..MAX_DISP-1
//  DISP_WIDTH  4    disparity output width, >= clog2(MAX_DISP)
//  (local) COST_WIDTH = clog2(CODE_WIDTH+1)
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  rst        in   1           asynchronous reset, active-high
//  in_valid   in   1           census_l/census_r valid
//  in_ready   out  1           block accepts a pixel pair
//  census_l   in   CODE_WIDTH  left-image Census code
//  census_r   in   CODE_WIDTH  right-image Census code, same pixel position
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts result
//  disparity  out  DISP_WIDTH  winning disparity
//  min_cost   out  COST_WIDTH  Hamming cost of winner
//  out_eol    out  1           result is last column of a row
//  out_eof    out  1           result is last pixel of frame
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, disparity=0, min_cost=0, out_eol=0,
//   out_eof=0, col/row counters=0, right history cleared to 0.
//   Reset mid-operation aborts the current pixel; nothing is emitted for it.
//  History: r_hist[0..MAX_DISP-1]. On accept, shift r_hist[k]<=r_hist[k-1]; r_hist[0]<=census_r.
//   r_hist[d] = right code at column col-d. Latch census_l, col, row.
//  dmax = min(col, MAX_DISP-1).
//   Candidates with col-d<0 are never evaluated; stale prior-row history is ignored.
//  FSM:
//   IDLE: in_ready=1. On in_valid&in_ready -> SEARCH; d<=0; best_cost<=all-ones; best_d<=0.
//   SEARCH: in_ready=0. cost = popcount(census_l_q ^ r_hist[d]).
//    If cost < best_cost (strict), update best_cost and best_d; ties keep the smaller d.
//    If d==dmax -> DONE, else d<=d+1. Exactly dmax+1 cycles.
//   DONE: out_valid=1 with disparity=best_d, min_cost=best_cost, out_eol, out_eof.
//    All outputs held stable while out_ready=0. On out_ready -> IDLE; out_valid=0 next cycle.
//  Latency: accept in cycle 0 -> out_valid first high in cycle dmax+2.
//   Throughput: one pixel per dmax+3 cycles minimum.
//  Counters: advance on accept. At col==WIDTH-1, col wraps to 0 and row increments.
//   At row==HEIGHT-1 && col==WIDTH-1, row wraps to 0.
//   out_eol = (latched col==WIDTH-1); out_eof = out_eol && (latched row==HEIGHT-1).
//  in_ready=0 in SEARCH and DONE; no overlap between pixels.
//  in_valid is ignored outside IDLE. Inputs need not be held after accept.
// TESTING
//  1 Reset: assert rst mid-SEARCH -> same cycle out_valid=0, in_ready=1; next pixel is treated as col 0.
//  2 First pixel, census_l=census_r=8'hA5 -> out_valid in cycle 2, disparity=0, min_cost=0.
//  3 Shifted row, r[x]=x, l[x]=r[x-5] (x>=5) -> at col 20, disparity=5, min_cost=0,
//    out_valid in cycle 17 after accept.
//  4 All codes 8'hFF -> disparity=0, min_cost=0 every pixel (tie picks smallest d).
//    l=8'h0F, r=8'hF0 at col 0 -> min_cost=8.
//  5 Backpressure: out_ready=0 for 10 cycles -> out_valid, disparity, min_cost held;
//    in_ready=0 throughout.
//  6 Full 320x240 frame -> 76800 results; out_eol on every col 319; out_eof only on the last;
//    next frame col 0 result uses d=0 only.

Source files
------------

// File: rtl/census_disparity_wta.sv
// Census-transform stereo matcher: per pixel, walks disparities 0..dmax one per cycle,
// computes Hamming cost against the right-code history and emits the winner-take-all minimum.
module census_disparity_wta #(
    parameter  int WIDTH      = 320,
    parameter  int HEIGHT     = 240,
    parameter  int CODE_WIDTH = 8,
    parameter  int MAX_DISP   = 16,
    parameter  int DISP_WIDTH = 4,
    localparam int COST_WIDTH = $clog2(CODE_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_WIDTH-1:0] census_l,
    input  logic [CODE_WIDTH-1:0] census_r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DISP_WIDTH-1:0] disparity,
    output logic [COST_WIDTH-1:0] min_cost,
    output logic                  out_eol,
    output logic                  out_eof
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                r_state;
    logic [CODE_WIDTH-1:0] r_hist [MAX_DISP];
    logic [CODE_WIDTH-1:0] r_cl;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_pix_col;
    logic                  r_pix_eol;
    logic                  r_pix_eof;
    logic [DISP_WIDTH-1:0] r_d;
    logic [DISP_WIDTH-1:0] r_best_d;
    logic [COST_WIDTH-1:0] r_best_cost;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DISP_WIDTH-1:0] r_disparity;
    logic [COST_WIDTH-1:0] r_min_cost;
    logic                  r_out_eol;
    logic                  r_out_eof;

    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic [DISP_WIDTH-1:0] w_dmax;
    logic [COST_WIDTH-1:0] w_cost;
    logic [COST_WIDTH-1:0] w_nbest_cost;
    logic [DISP_WIDTH-1:0] w_nbest_d;

    function automatic logic [COST_WIDTH-1:0] popcount(input logic [CODE_WIDTH-1:0] v);
        logic [COST_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < CODE_WIDTH; i++) begin
            c = c + COST_WIDTH'(v[i]);
        end
        return c;
    endfunction

    // Candidate cost, running minimum and search bound for the pixel in flight
    always_comb begin
        w_accept   = in_valid & r_in_ready;
        w_col_last = (r_col == COL_W'(WIDTH - 1));
        w_row_last = (r_row == ROW_W'(HEIGHT - 1));
        if (int'(r_pix_col) >= MAX_DISP - 1) begin
            w_dmax = DISP_WIDTH'(MAX_DISP - 1);
        end else begin
            w_dmax = DISP_WIDTH'(r_pix_col);
        end
        w_cost = popcount(r_cl ^ r_hist[r_d]);
        // Strict compare: on a tie the earlier (smaller) disparity stays the winner
        if (w_cost < r_best_cost) begin
            w_nbest_cost = w_cost;
            w_nbest_d    = r_d;
        end else begin
            w_nbest_cost = r_best_cost;
            w_nbest_d    = r_best_d;
        end
    end

    // Right-code history, left-code latch and raster position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MAX_DISP; k++) begin
                r_hist[k] <= '0;
            end
            r_cl      <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_pix_col <= '0;
            r_pix_eol <= 1'b0;
            r_pix_eof <= 1'b0;
        end else if (w_accept) begin
            for (int k = MAX_DISP - 1; k > 0; k--) begin
                r_hist[k] <= r_hist[k-1];
            end
            r_hist[0] <= census_r;
            r_cl      <= census_l;
            r_pix_col <= r_col;
            r_pix_eol <= w_col_last;
            r_pix_eof <= w_col_last & w_row_last;
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_d         <= '0;
            r_best_d    <= '0;
            r_best_cost <= {COST_WIDTH{1'b1}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_disparity <= '0;
            r_min_cost  <= '0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state     <= SEARCH;
                        r_in_ready  <= 1'b0;
                        r_d         <= '0;
                        r_best_d    <= '0;
                        r_best_cost <= {COST_WIDTH{1'b1}};
                    end
                end
                SEARCH: begin
                    r_best_cost <= w_nbest_cost;
                    r_best_d    <= w_nbest_d;
                    if (r_d == w_dmax) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_disparity <= w_nbest_d;
                        r_min_cost  <= w_nbest_cost;
                        r_out_eol   <= r_pix_eol;
                        r_out_eof   <= r_pix_eof;
                    end else begin
                        r_d <= r_d + DISP_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign disparity = r_disparity;
    assign min_cost  = r_min_cost;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;

endmodule

// File: tb/tb_census_disparity_wta.sv
// Randomized bench for census_disparity_wta on a reduced frame, checked against a
// per-row reference model of the winner-take-all Hamming search.
module tb_census_disparity_wta;

    localparam int W  = 24;
    localparam int H  = 3;
    localparam int MD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] census_l;
    logic [7:0] census_r;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] disparity;
    logic [3:0] min_cost;
    logic       out_eol;
    logic       out_eof;

    int         n_vec = 0;
    int         n_err = 0;
    int         m_col = 0;
    int         m_row = 0;
    logic [7:0] rrow [W];
    int         last_d;
    int         last_c;

    census_disparity_wta #(
        .WIDTH(W), .HEIGHT(H), .CODE_WIDTH(8), .MAX_DISP(MD), .DISP_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .census_l(census_l), .census_r(census_r), .out_valid(out_valid),
        .out_ready(out_ready), .disparity(disparity), .min_cost(min_cost),
        .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (col %0d row %0d, t=%0t)", tag, got, exp, m_col, m_row, $time);
        end
    endtask

    // Apply one pixel pair starting at a negedge; abort=1 resets while the result is presented.
    task automatic do_pixel(input logic [7:0] l, input logic [7:0] r, input int hold, input bit abort);
        int exp_d, exp_c, dmax, c, k;
        bit eol, eof;
        rrow[m_col] = r;
        dmax  = (m_col < MD - 1) ? m_col : MD - 1;
        exp_c = 1000;
        exp_d = 0;
        for (int d = 0; d <= dmax; d++) begin
            c = $countones(l ^ rrow[m_col - d]);
            if (c < exp_c) begin
                exp_c = c;
                exp_d = d;
            end
        end
        eol = (m_col == W - 1);
        eof = eol && (m_row == H - 1);
        last_d = exp_d;
        last_c = exp_c;

        check_eq("in_ready_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        census_l = l;
        census_r = r;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        census_l = 8'($urandom);
        census_r = 8'($urandom);
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("latency", k, dmax + 2);
        check_eq("disparity", int'(disparity), exp_d);
        check_eq("min_cost", int'(min_cost), exp_c);
        check_eq("out_eol", int'(out_eol), int'(eol));
        check_eq("out_eof", int'(out_eof), int'(eof));
        check_eq("in_ready_busy", int'(in_ready), 0);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check_eq("hold_valid", int'(out_valid), 1);
            check_eq("hold_disp", int'(disparity), exp_d);
            check_eq("hold_cost", int'(min_cost), exp_c);
            check_eq("hold_ready", int'(in_ready), 0);
        end
        if (abort) begin
            rst = 1'b1;
            #1;
            check_eq("rst_out_valid", int'(out_valid), 0);
            check_eq("rst_in_ready", int'(in_ready), 1);
            check_eq("rst_disparity", int'(disparity), 0);
            @(negedge clk);
            rst = 1'b0;
            m_col = 0;
            m_row = 0;
        end else begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("release_valid", int'(out_valid), 0);
            check_eq("release_ready", int'(in_ready), 1);
            if (eol) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        census_l  = 8'h00;
        census_r  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset_valid", int'(out_valid), 0);
        check_eq("reset_ready", int'(in_ready), 1);
        check_eq("reset_disp", int'(disparity), 0);
        check_eq("reset_cost", int'(min_cost), 0);
        check_eq("reset_eol", int'(out_eol), 0);
        check_eq("reset_eof", int'(out_eof), 0);
        rst = 1'b0;
        @(negedge clk);

        // First pixel identical codes, then abort with reset while DONE
        do_pixel(8'hA5, 8'hA5, 0, 1'b1);
        check_eq("first_disp", last_d, 0);

        // Reset in the middle of a search on col 1
        do_pixel(8'h3C, 8'h3C, 0, 1'b0);
        in_valid = 1'b1;
        census_l = 8'h11;
        census_r = 8'h22;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("search_busy", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", int'(out_valid), 0);
        check_eq("midrst_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        m_col = 0;
        m_row = 0;
        // Post-reset pixel must be col 0: only d=0, complementary halves cost 8
        do_pixel(8'h0F, 8'hF0, 0, 1'b0);
        check_eq("col0_cost8", last_c, 8);
        // Finish row 0 with random codes
        for (int x = 1; x < W; x++) do_pixel(8'($urandom), 8'($urandom), 0, 1'b0);

        // Row 1: right code = column, left = right shifted by 5; backpressure at col 20
        for (int x = 0; x < W; x++) begin
            do_pixel((x >= 5) ? 8'(x - 5) : 8'($urandom), 8'(x), (x == 20) ? 10 : 0, 1'b0);
            if (x == 20) begin
                check_eq("shift_disp", last_d, 5);
                check_eq("shift_cost", last_c, 0);
            end
        end

        // Row 2: all-ones codes, every pixel ties at cost 0 -> d=0
        for (int x = 0; x < W; x++) begin
            do_pixel(8'hFF, 8'hFF, 0, 1'b0);
        end

        // Two more full frames of random codes with sparse bits to provoke ties
        for (int p = 0; p < 2 * W * H; p++) begin
            do_pixel(8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
